// File: rtl/regfile_access_pkg.sv
// Shared types and default widths for the register-file access master.
package regfile_access_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BE_WIDTH   = DEF_DATA_WIDTH / 8;

    // Transaction sequencer states: one command in flight at a time.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // One bus command at the default widths.
    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
        logic [DEF_BE_WIDTH-1:0]   be;
    } cmd_t;

endpackage

// File: rtl/regfile_access_master_if.sv
// Command/response bus of the register-file access master.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the initiator holds valid and its payload stable until then, and
// ready may depend on state but never on valid.
interface regfile_access_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) ();
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [BE_WIDTH-1:0]   cmd_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    // Side that issues commands and consumes responses.
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata
    );

    // Side that accepts commands and produces responses (the access master).
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata
    );
endinterface

// File: rtl/rfam_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra MSB so full and empty
// are distinguishable without a separate flag.
module rfam_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == DEPTH_CNT);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    // Pointer update; reset flushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= din;
    end
endmodule

// File: rtl/regfile_access_master.sv
// Bus-side initiator for the register file: buffers commands, issues them one
// at a time on write port 0 / read port 0 and returns in-order responses.
module regfile_access_master
    import regfile_access_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CMD_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] PARK_ADDR = {ADDR_WIDTH{1'b1}}
) (
    input  logic                          clk,
    input  logic                          rst,
    regfile_access_master_if.slave        bus,
    output logic                          busy,
    output logic [$clog2(CMD_DEPTH):0]    fifo_count,
    output state_t                        fsm_state,
    output logic                          wr_en_0,
    output logic [ADDR_WIDTH-1:0]         wr_addr_0,
    output logic [DATA_WIDTH-1:0]         wr_data_0,
    output logic [DATA_WIDTH/8-1:0]       wr_be_0,
    output logic [ADDR_WIDTH-1:0]         rd_addr_0,
    input  logic [DATA_WIDTH-1:0]         rd_data_0
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int ENTRY_W  = 1 + ADDR_WIDTH + DATA_WIDTH + BE_WIDTH;

    state_t                state;
    state_t                state_next;
    logic                  pop;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_dout;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic [BE_WIDTH-1:0]   head_be;
    logic                  cmd_q_write;

    // No bypass: a full FIFO refuses pushes even when popping this cycle.
    assign bus.cmd_ready = !rst && !fifo_full;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign busy          = !fifo_empty || (state != IDLE);
    assign fsm_state     = state;
    assign {head_write, head_addr, head_wdata, head_be} = fifo_dout;

    rfam_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_be}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and FIFO pop: pop only from IDLE, so each command takes
    // IDLE -> ISSUE -> RESP.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Regfile port registers: loaded on pop so they are live exactly during
    // ISSUE; otherwise the write strobe is low and the read address parked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_0     <= 1'b0;
            wr_addr_0   <= '0;
            wr_data_0   <= '0;
            wr_be_0     <= '0;
            rd_addr_0   <= PARK_ADDR;
            cmd_q_write <= 1'b0;
        end else begin
            wr_en_0   <= 1'b0;
            rd_addr_0 <= PARK_ADDR;
            if (pop) begin
                cmd_q_write <= head_write;
                if (head_write) begin
                    wr_en_0   <= 1'b1;
                    wr_addr_0 <= head_addr;
                    wr_data_0 <= head_wdata;
                    wr_be_0   <= head_be;
                end else begin
                    rd_addr_0 <= head_addr;
                end
            end
        end
    end

    // Response register: capture read data at the end of ISSUE, hold until
    // the consumer accepts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_write <= 1'b0;
            bus.rsp_rdata <= '0;
        end else if (state == ISSUE) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_write <= cmd_q_write;
            bus.rsp_rdata <= cmd_q_write ? '0 : rd_data_0;
        end else if (state == RESP && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_access_master.sv
// Bench for regfile_access_master: a small regfile model (CTRL 0x00 RW,
// INT_FLAGS 0x08 read-clean) and a command-order reference model.
module tb_regfile_access_master;
    import regfile_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [2:0]  fifo_count;
    state_t      fsm_state;
    logic        wr_en_0;
    logic [7:0]  wr_addr_0;
    logic [31:0] wr_data_0;
    logic [3:0]  wr_be_0;
    logic [7:0]  rd_addr_0;
    logic [31:0] rd_data_0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] rf_mem  [256] = '{default: '0};
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    regfile_access_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    regfile_access_master dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .fifo_count (fifo_count),
        .fsm_state  (fsm_state),
        .wr_en_0    (wr_en_0),
        .wr_addr_0  (wr_addr_0),
        .wr_data_0  (wr_data_0),
        .wr_be_0    (wr_be_0),
        .rd_addr_0  (rd_addr_0),
        .rd_data_0  (rd_data_0)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Regfile model: byte-enabled writes, INT_FLAGS cleared by any read access,
    // 0xFF maps to nothing. Also counts write strobes and non-parked reads.
    always @(posedge clk) begin
        if (wr_en_0 && wr_addr_0 != 8'hFF)
            for (int b = 0; b < 4; b++)
                if (wr_be_0[b]) rf_mem[wr_addr_0][b*8 +: 8] <= wr_data_0[b*8 +: 8];
        if (rd_addr_0 == 8'h08) rf_mem[8'h08] <= 32'h0;
        if (wr_en_0) wr_cnt <= wr_cnt + 1;
        if (rd_addr_0 != 8'hFF) rd_cnt <= rd_cnt + 1;
    end

    assign rd_data_0 = (rd_addr_0 == 8'hFF) ? 32'h0 : rf_mem[rd_addr_0];

    // Reference: apply one command to the shadow register file and return the
    // response data it must produce.
    function automatic logic [31:0] ref_access(input logic w, input logic [7:0] a,
                                               input logic [31:0] d, input logic [3:0] be);
        logic [31:0] v;
        v = 32'h0;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
        end else begin
            v = ref_mem[a];
            if (a == 8'h08) ref_mem[a] = 32'h0;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit expect_rsp, output bit acc);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_be    = be;
        acc = bus.cmd_ready;
        tick();
        bus.cmd_valid = 1'b0;
        if (acc && expect_rsp) exp_q.push_back({w, ref_access(w, a, d, be)});
    endtask

    task automatic collect(input string tag);
        int          waited;
        logic [32:0] e;
        waited = 0;
        while (bus.rsp_valid !== 1'b1 && waited < 30) begin
            tick();
            waited++;
        end
        check({tag, " rsp_valid"}, bus.rsp_valid, 1);
        if (bus.rsp_valid === 1'b1) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                check({tag, " rsp hold"}, bus.rsp_valid, 1);
            end
            check({tag, " rsp expected"}, exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, " rsp_write"}, bus.rsp_write, e[32]);
                check({tag, " rsp_rdata"}, bus.rsp_rdata, e[31:0]);
            end
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
    endtask

    // Watchdog.
    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Directed and randomized stimulus.
    initial begin
        bit          acc;
        int          wc;
        int          rc;
        int          k;
        logic        w;
        logic [7:0]  a;

        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_be    = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("rst wr_en_0",   wr_en_0, 0);
        check("rst wr_addr_0", wr_addr_0, 0);
        check("rst wr_data_0", wr_data_0, 0);
        check("rst wr_be_0",   wr_be_0, 0);
        check("rst rd_addr_0", rd_addr_0, 8'hFF);
        check("rst rsp_valid", bus.rsp_valid, 0);
        check("rst rsp_rdata", bus.rsp_rdata, 0);
        check("rst rsp_write", bus.rsp_write, 0);
        check("rst busy",      busy, 0);
        check("rst cmd_ready", bus.cmd_ready, 0);
        check("rst fifo_count", fifo_count, 0);
        check("rst state",     fsm_state, IDLE);
        rst = 1'b0;
        tick();
        check("post rst cmd_ready", bus.cmd_ready, 1);

        // 1: write latency and single strobe.
        wc = wr_cnt;
        push(1'b1, 8'h00, 32'hDEADBEEF, 4'hF, 1'b1, acc);
        check("t1 accepted", acc, 1);
        check("t1 busy", busy, 1);
        check("t1 wr_en before issue", wr_en_0, 0);
        tick();
        check("t1 wr_en_0",   wr_en_0, 1);
        check("t1 wr_addr_0", wr_addr_0, 8'h00);
        check("t1 wr_data_0", wr_data_0, 32'hDEADBEEF);
        check("t1 wr_be_0",   wr_be_0, 4'hF);
        check("t1 state issue", fsm_state, ISSUE);
        check("t1 rd park in write", rd_addr_0, 8'hFF);
        tick();
        check("t1 wr_en_0 low", wr_en_0, 0);
        check("t1 rsp_valid N+2", bus.rsp_valid, 1);
        check("t1 rsp_write", bus.rsp_write, 1);
        check("t1 rsp_rdata", bus.rsp_rdata, 0);
        check("t1 one strobe", wr_cnt - wc, 1);
        collect("t1");
        tick();
        check("t1 strobe total", wr_cnt - wc, 1);

        // 2: read back.
        push(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, acc);
        check("t2 accepted", acc, 1);
        collect("t2");
        check("t2 rdata value", bus.rsp_rdata, 32'hDEADBEEF);

        // 3: read-clean register untouched while idle, then cleared by one read.
        push(1'b1, 8'h08, 32'h5, 4'hF, 1'b1, acc);
        collect("t3 preload");
        rc = rd_cnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t3 idle park", rd_addr_0, 8'hFF);
        end
        check("t3 no idle reads", rd_cnt - rc, 0);
        push(1'b0, 8'h08, 32'h0, 4'h0, 1'b1, acc);
        collect("t3 read1");
        check("t3 first flags", bus.rsp_rdata, 32'h5);
        push(1'b0, 8'h08, 32'h0, 4'h0, 1'b1, acc);
        collect("t3 read2");
        check("t3 second flags", bus.rsp_rdata, 32'h0);
        check("t3 two accesses", rd_cnt - rc, 2);

        // 4: back-pressure fills the FIFO.
        for (int i = 0; i < 5; i++) begin
            push(1'($urandom_range(0, 1)), 8'h20 + 8'(i), $urandom, 4'($urandom_range(0, 15)),
                 1'b1, acc);
            check("t4 accepted", acc, 1);
        end
        check("t4 fifo full count", fifo_count, 4);
        check("t4 busy", busy, 1);
        check("t4 cmd_ready low", bus.cmd_ready, 0);
        push(1'b1, 8'h30, 32'h1, 4'hF, 1'b1, acc);
        check("t4 sixth refused", acc, 0);
        for (int i = 0; i < 5; i++) collect("t4 drain");
        repeat (3) tick();
        check("t4 busy cleared", busy, 0);
        check("t4 queue empty", exp_q.size(), 0);

        // 5: byte enables, including an all-zero mask.
        push(1'b1, 8'h00, 32'h0, 4'hF, 1'b1, acc);
        collect("t5 clear");
        push(1'b1, 8'h00, 32'h11223344, 4'b0100, 1'b1, acc);
        collect("t5 partial");
        push(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, acc);
        collect("t5 readback");
        check("t5 merged value", bus.rsp_rdata, 32'h00220000);
        wc = wr_cnt;
        push(1'b1, 8'h00, 32'hFFFFFFFF, 4'b0000, 1'b1, acc);
        tick();
        check("t5 be0 wr_en_0", wr_en_0, 1);
        check("t5 be0 wr_be_0", wr_be_0, 0);
        collect("t5 be0 ack");
        check("t5 be0 strobe", wr_cnt - wc, 1);
        push(1'b0, 8'h00, 32'h0, 4'h0, 1'b1, acc);
        collect("t5 be0 readback");
        check("t5 be0 unchanged", bus.rsp_rdata, 32'h00220000);

        // 6: reset during ISSUE of a write drops it.
        push(1'b1, 8'h10, 32'hAAAA5555, 4'hF, 1'b1, acc);
        collect("t6 baseline");
        wc = wr_cnt;
        push(1'b1, 8'h10, 32'h12345678, 4'hF, 1'b0, acc);
        tick();
        check("t6 in issue", wr_en_0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6 wr_en_0 async drop", wr_en_0, 0);
        check("t6 rsp_valid", bus.rsp_valid, 0);
        check("t6 busy", busy, 0);
        check("t6 cmd_ready", bus.cmd_ready, 0);
        check("t6 fifo flushed", fifo_count, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6 cmd_ready in rst", bus.cmd_ready, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6 no stale rsp", bus.rsp_valid, 0);
        end
        check("t6 no write", wr_cnt - wc, 0);
        push(1'b0, 8'h10, 32'h0, 4'h0, 1'b1, acc);
        collect("t6 readback");
        check("t6 old value kept", bus.rsp_rdata, 32'hAAAA5555);

        // Random bursts against the reference model.
        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) begin
                case ($urandom_range(0, 2))
                    0:       a = 8'h00;
                    1:       a = 8'h08;
                    default: a = 8'h10 + 8'($urandom_range(0, 15));
                endcase
                w = 1'($urandom_range(0, 1));
                push(w, a, $urandom, 4'($urandom_range(0, 15)), 1'b1, acc);
                check("rand accepted", acc, 1);
            end
            for (int j = 0; j < k; j++) collect("rand");
        end
        repeat (3) tick();
        check("final queue empty", exp_q.size(), 0);
        check("final busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
